// File: rtl/em_sensor_array.sv
// EM sensor array capture: rate-selectable sampling, per-bit debounce, and a
// sequence-tagged publish to the CPU over a ready/complete handshake.
module em_sensor_array #(
  parameter int unsigned NUM_SENSORS  = 8,
  parameter int unsigned FAST_DIV     = 4,
  parameter int unsigned SLOW_DIV     = 64,
  parameter int unsigned FILTER_DEPTH = 3,
  parameter int unsigned SEQ_W        = 8
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Enable,
  input  logic [1:0]                   Mode,
  input  logic [NUM_SENSORS-1:0]       EMReading,
  input  logic                         CPUReadComplete,
  output logic [SEQ_W+NUM_SENSORS-1:0] EMResult,
  output logic [2:0]                   ErrorCode,
  output logic                         EMValReady,
  output logic                         Overrun
);

  localparam int unsigned PW = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
  localparam logic [PW-1:0] FastMax = PW'(FAST_DIV - 1);
  localparam logic [PW-1:0] SlowMax = PW'(SLOW_DIV - 1);

  typedef enum logic [1:0] {StStop, StIdle, StSample, StReady} state_e;

  state_e                                 state_q, state_d;
  logic [PW-1:0]                          presc_q, presc_d;
  logic [SEQ_W-1:0]                       seq_q, seq_d;
  logic [FILTER_DEPTH-1:0][NUM_SENSORS-1:0] hist_q, hist_d, hist_shift;
  logic [NUM_SENSORS-1:0]                 deb_q, deb_d, deb_next;
  logic [SEQ_W+NUM_SENSORS-1:0]           result_q, result_d;
  logic [2:0]                             err_q, err_d;
  logic                                   ready_q, ready_d;
  logic                                   overrun_q, overrun_d;
  logic [1:0]                             mode_q, mode_d;

  logic stop_req, bad_mode, running, switch_mode, tick, publish;
  logic [PW-1:0] presc_max;
  logic [NUM_SENSORS-1:0] all_one, any_one;

  assign stop_req    = !Enable || (Mode == 2'd0);
  assign bad_mode    = !stop_req && (Mode == 2'd3);
  assign running     = (state_q == StSample) || (state_q == StReady);
  assign switch_mode = running && !stop_req && !bad_mode && (Mode != mode_q);
  assign presc_max   = (Mode == 2'd2) ? SlowMax : FastMax;
  assign tick        = running && !stop_req && !bad_mode && !switch_mode &&
                       (presc_q == presc_max);
  assign publish     = tick && ((state_q == StSample) || CPUReadComplete);

  // A bit follows the input only once every history slot agrees.
  always_comb begin
    hist_shift[0] = EMReading;
    for (int i = 1; i < int'(FILTER_DEPTH); i++) hist_shift[i] = hist_q[i-1];
    all_one = '1;
    any_one = '0;
    for (int i = 0; i < int'(FILTER_DEPTH); i++) begin
      all_one = all_one & hist_shift[i];
      any_one = any_one | hist_shift[i];
    end
    deb_next = all_one | (deb_q & any_one);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= StStop;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_req || bad_mode) begin
      state_d = StStop;
    end else begin
      unique case (state_q)
        StStop:   state_d = StIdle;
        StIdle:   state_d = StSample;
        StSample: if (tick) state_d = StReady;
        StReady:  if (CPUReadComplete && !tick) state_d = StSample;
        default:  state_d = StStop;
      endcase
    end
  end

  always_comb begin
    presc_d   = presc_q;
    seq_d     = seq_q;
    hist_d    = hist_q;
    deb_d     = deb_q;
    result_d  = result_q;
    err_d     = err_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    mode_d    = mode_q;
    if (stop_req) begin
      presc_d   = '0;
      ready_d   = 1'b0;
      overrun_d = 1'b0;
      err_d     = 3'd0;
    end else if (bad_mode) begin
      presc_d = '0;
      ready_d = 1'b0;
      err_d   = 3'd4;
    end else begin
      mode_d = Mode;
      err_d  = (state_q == StStop) ? 3'd1 : ((Mode == 2'd2) ? 3'd3 : 3'd2);
      if (!running || switch_mode || presc_q == presc_max) presc_d = '0;
      else                                                 presc_d = presc_q + 1'b1;
      if (tick) begin
        hist_d = hist_shift;
        deb_d  = deb_next;
      end
      if (publish) begin
        result_d = {seq_q, deb_next};
        seq_d    = seq_q + 1'b1;
        ready_d  = 1'b1;
      end else if (state_q == StReady) begin
        if (tick)                 overrun_d = 1'b1;
        else if (CPUReadComplete) ready_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc_q   <= '0;
      seq_q     <= '0;
      hist_q    <= '0;
      deb_q     <= '0;
      result_q  <= '0;
      err_q     <= 3'd0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      mode_q    <= 2'd0;
    end else begin
      presc_q   <= presc_d;
      seq_q     <= seq_d;
      hist_q    <= hist_d;
      deb_q     <= deb_d;
      result_q  <= result_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      mode_q    <= mode_d;
    end
  end

  assign EMResult   = result_q;
  assign ErrorCode  = err_q;
  assign EMValReady = ready_q;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_em_sensor_array.sv
// Directed bench for em_sensor_array with default parameters; expected values
// are hand-derived from the block's timing (first publish after edge DIV+2).
module tb_em_sensor_array;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Enable;
  logic [1:0]  Mode;
  logic [7:0]  EMReading;
  logic        CPUReadComplete;
  logic [15:0] EMResult;
  logic [2:0]  ErrorCode;
  logic        EMValReady;
  logic        Overrun;

  int total = 0;
  int bad   = 0;

  em_sensor_array dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Enable          (Enable),
    .Mode            (Mode),
    .EMReading       (EMReading),
    .CPUReadComplete (CPUReadComplete),
    .EMResult        (EMResult),
    .ErrorCode       (ErrorCode),
    .EMValReady      (EMValReady),
    .Overrun         (Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Leaves time just after an edge, so the next rising edge is "edge 1".
  task automatic do_reset();
    Rst_n = 1'b0; Enable = 1'b0; Mode = 2'd0; EMReading = '0; CPUReadComplete = 1'b0;
    step(2);
    Rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    step(10);
    total++; if (EMResult !== 16'h0000) begin bad++;
      $display("FAIL reset_result got=%h want=0000", EMResult); end
    total++; if (ErrorCode !== 3'd0) begin bad++;
      $display("FAIL reset_err got=%0d want=0", ErrorCode); end
    total++; if (EMValReady !== 1'b0) begin bad++;
      $display("FAIL reset_ready got=%b want=0", EMValReady); end
    total++; if (Overrun !== 1'b0) begin bad++;
      $display("FAIL reset_overrun got=%b want=0", Overrun); end
  endtask

  task automatic test_fast_debounce();
    do_reset();
    EMReading = 8'h6B; Enable = 1'b1; Mode = 2'd1; CPUReadComplete = 1'b1;
    step(1);
    total++; if (ErrorCode !== 3'd1) begin bad++;
      $display("FAIL fast_err_idle got=%0d want=1", ErrorCode); end
    step(1);
    total++; if (ErrorCode !== 3'd2) begin bad++;
      $display("FAIL fast_err_active got=%0d want=2", ErrorCode); end
    step(3);
    total++; if (EMValReady !== 1'b0) begin bad++;
      $display("FAIL fast_ready_edge5 got=%b want=0", EMValReady); end
    step(1);
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h0000) begin bad++;
      $display("FAIL fast_pub0 got=%b/%h want=1/0000", EMValReady, EMResult); end
    step(1);
    total++; if (EMValReady !== 1'b0) begin bad++;
      $display("FAIL fast_ack got=%b want=0", EMValReady); end
    step(3);
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h0100) begin bad++;
      $display("FAIL fast_pub1 got=%b/%h want=1/0100", EMValReady, EMResult); end
    step(4);
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h026B) begin bad++;
      $display("FAIL fast_pub2 got=%b/%h want=1/026b", EMValReady, EMResult); end
  endtask

  task automatic test_overrun();
    do_reset();
    EMReading = 8'h6B; Enable = 1'b1; Mode = 2'd2; CPUReadComplete = 1'b0;
    step(65);
    total++; if (EMValReady !== 1'b0) begin bad++;
      $display("FAIL slow_ready_edge65 got=%b want=0", EMValReady); end
    step(1);
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h0000 || ErrorCode !== 3'd3) begin
      bad++;
      $display("FAIL slow_pub0 got=%b/%h/%0d want=1/0000/3", EMValReady, EMResult, ErrorCode);
    end
    step(63);
    total++; if (Overrun !== 1'b0) begin bad++;
      $display("FAIL slow_overrun_early got=%b want=0", Overrun); end
    step(1);
    total++; if (Overrun !== 1'b1 || EMResult !== 16'h0000 || EMValReady !== 1'b1) begin
      bad++;
      $display("FAIL slow_overrun got=%b/%h/%b want=1/0000/1", Overrun, EMResult, EMValReady);
    end
    Enable = 1'b0;
    step(1);
    total++; if (Overrun !== 1'b0 || ErrorCode !== 3'd0 || EMValReady !== 1'b0) begin bad++;
      $display("FAIL disable_clear got=%b/%0d/%b want=0/0/0", Overrun, ErrorCode, EMValReady);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    EMReading = 8'h6B; Enable = 1'b1; Mode = 2'd1; CPUReadComplete = 1'b1;
    step(6);
    total++; if (EMResult !== 16'h0000 || EMValReady !== 1'b1) begin bad++;
      $display("FAIL sw_pub0 got=%h/%b want=0000/1", EMResult, EMValReady); end
    step(2);
    Mode = 2'd2;
    step(1);
    total++; if (ErrorCode !== 3'd3 || EMValReady !== 1'b0) begin bad++;
      $display("FAIL sw_err got=%0d/%b want=3/0", ErrorCode, EMValReady); end
    step(63);
    total++; if (EMValReady !== 1'b0) begin bad++;
      $display("FAIL sw_early_tick got=%b want=0", EMValReady); end
    step(1);
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h0100) begin bad++;
      $display("FAIL sw_pub1 got=%b/%h want=1/0100", EMValReady, EMResult); end
  endtask

  task automatic test_collision_and_invalid();
    do_reset();
    EMReading = 8'hFF; Enable = 1'b1; Mode = 2'd1; CPUReadComplete = 1'b0;
    step(6);
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h0000) begin bad++;
      $display("FAIL col_pub0 got=%b/%h want=1/0000", EMValReady, EMResult); end
    step(3);
    CPUReadComplete = 1'b1;
    step(1);
    CPUReadComplete = 1'b0;
    total++; if (EMValReady !== 1'b1 || EMResult !== 16'h0100 || Overrun !== 1'b0) begin
      bad++;
      $display("FAIL col_tick got=%b/%h/%b want=1/0100/0", EMValReady, EMResult, Overrun);
    end
    step(4);
    total++; if (Overrun !== 1'b1 || EMResult !== 16'h0100) begin bad++;
      $display("FAIL col_overrun got=%b/%h want=1/0100", Overrun, EMResult); end
    Mode = 2'd3;
    step(1);
    total++; if (ErrorCode !== 3'd4 || EMValReady !== 1'b0 || Overrun !== 1'b1) begin bad++;
      $display("FAIL invalid_mode got=%0d/%b/%b want=4/0/1", ErrorCode, EMValReady, Overrun);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    EMReading = 8'h0F; Enable = 1'b1; Mode = 2'd1; CPUReadComplete = 1'b0;
    step(10);
    total++; if (Overrun !== 1'b1 || EMValReady !== 1'b1) begin bad++;
      $display("FAIL async_pre got=%b/%b want=1/1", Overrun, EMValReady); end
    Rst_n = 1'b0;
    #2;
    total++; if (Overrun !== 1'b0 || EMValReady !== 1'b0 || ErrorCode !== 3'd0 ||
                 EMResult !== 16'h0000) begin bad++;
      $display("FAIL async_reset got=%b/%b/%0d/%h want=0/0/0/0000",
               Overrun, EMValReady, ErrorCode, EMResult);
    end
    Rst_n = 1'b1;
  endtask

  task automatic test_seq_wrap();
    do_reset();
    EMReading = 8'h00; Enable = 1'b1; Mode = 2'd1; CPUReadComplete = 1'b1;
    step(6);
    total++; if (EMResult !== 16'h0000 || EMValReady !== 1'b1) begin bad++;
      $display("FAIL wrap_first got=%h/%b want=0000/1", EMResult, EMValReady); end
    step(1020);
    total++; if (EMResult !== 16'hFF00 || EMValReady !== 1'b1) begin bad++;
      $display("FAIL wrap_ff got=%h/%b want=ff00/1", EMResult, EMValReady); end
    step(4);
    total++; if (EMResult !== 16'h0000 || EMValReady !== 1'b1) begin bad++;
      $display("FAIL wrap_00 got=%h/%b want=0000/1", EMResult, EMValReady); end
  endtask

  initial begin
    test_reset();
    test_fast_debounce();
    test_overrun();
    test_mode_switch();
    test_collision_and_invalid();
    test_async_reset();
    test_seq_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
